// File: rtl/adder_sum_splitter.sv
// Digit-serial subtractor: diff = minuend - subtrahend, CHUNK bits/cycle, ADDER_SUM_SPLITTER_SATURATE_EN clamps diff.
// Latency: out_valid rises NCHUNK edges after accept; one op per NCHUNK+2 cycles minimum.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module adder_sum_splitter #(
    parameter int WIDTH = 74,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             underflow,
    output logic             overflow
);

    localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
    localparam int EXT    = NCHUNK * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [EXT-1:0]   m_q, m_d, s_q, s_d, r_q, r_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             underflow_q, underflow_d;
    logic             overflow_q, overflow_d;

    logic [CHUNK:0]       step;
    logic [EXT+CHUNK-1:0] r_cat;
    logic [EXT-1:0]       r_shift;
    logic                 fin_uf, fin_ov;

    always_comb begin
        // Operands shift right so the active chunk is always the low CHUNK bits.
        step    = {1'b0, m_q[CHUNK-1:0]} - {1'b0, s_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
        r_cat   = {step[CHUNK-1:0], r_q};
        r_shift = r_cat[EXT+CHUNK-1:CHUNK];
        fin_uf  = step[CHUNK];
        fin_ov  = !fin_uf && r_shift[WIDTH];

        state_d     = state_q;
        m_d         = m_q;
        s_d         = s_q;
        r_d         = r_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d      = EXT'(minuend);
                    s_d      = EXT'(subtrahend);
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                m_d      = m_q >> CHUNK;
                s_d      = s_q >> CHUNK;
                r_d      = r_shift;
                borrow_d = step[CHUNK];
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    underflow_d = fin_uf;
                    overflow_d  = fin_ov;
`ifdef ADDER_SUM_SPLITTER_SATURATE_EN
                    if (fin_uf)
                        diff_d = '0;
                    else if (fin_ov)
                        diff_d = '1;
                    else
                        diff_d = r_shift[WIDTH-1:0];
`else
                    diff_d = r_shift[WIDTH-1:0];
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            s_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/adder_sum_splitter.md
Name: adder_sum_splitter

Overview:
- Inverse end of the registered-adder benchmark. Takes a WIDTH+1-bit sum and one WIDTH-bit operand, and recovers the other operand: diff = minuend - subtrahend.
- Digit-serial subtractor: processes CHUNK bits per cycle with a borrow register, behind valid/ready handshakes.
- Sits downstream of the adder benchmark as a round-trip checker and digit-serial arithmetic benchmark.

Parameters:
- WIDTH, 74, operand width; minuend is WIDTH+1 bits, diff is WIDTH bits.
- CHUNK, 16, bits processed per cycle; must be >= 1.
- NCHUNK (localparam), ceil((WIDTH+1)/CHUNK), number of RUN cycles; 5 at defaults.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept.
- minuend  input  WIDTH+1  sum to split.
- subtrahend  input  WIDTH  known operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  recovered operand.
- underflow  output  1  minuend < subtrahend.
- overflow  output  1  minuend - subtrahend >= 2^WIDTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state IDLE, out_valid=0, diff=0, underflow=0, overflow=0, chunk index=0, borrow=0. in_ready is 0 while reset is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 (combinational: state==IDLE && !reset).
  - On an edge with in_valid && in_ready: capture minuend and subtrahend into internal registers (zero-extended to NCHUNK*CHUNK bits), clear borrow, set index=0, go to RUN.
  - Inputs may change freely after capture.
- RUN:
  - in_ready = 0.
  - Each edge: chunk[index] = m_chunk - s_chunk - borrow; borrow <= borrow-out; index++.
  - On the edge processing index NCHUNK-1, go to DONE and set out_valid=1.
  - out_valid therefore rises exactly NCHUNK edges after the accept edge.
- Result formation, registered on entry to DONE:
  - underflow = final borrow-out.
  - overflow = !underflow && result bit WIDTH == 1.
  - diff = result bits [WIDTH-1:0] (modulo 2^WIDTH), subject to the optional feature below.
  - underflow and overflow are mutually exclusive.
- DONE:
  - out_valid = 1; diff and flags held stable.
  - in_valid is ignored.
  - On an edge with out_valid && out_ready: out_valid <= 0, go to IDLE. diff and flags keep their last values.
  - No same-cycle accept; in_ready rises the cycle after the output handshake.
  - Throughput: one operation per NCHUNK+2 cycles minimum.
- Partial last chunk: bits above WIDTH are zero in both operands and do not affect the flags.
- CHUNK >= WIDTH+1: NCHUNK=1, single RUN cycle.
- reset in RUN or DONE: abort immediately to IDLE. The pending result is discarded, out_valid=0, and no late out_valid ever appears.

Optional Feature:
- Macro: ADDER_SUM_SPLITTER_SATURATE_EN.
- Defined: on underflow, diff is forced to 0; on overflow, diff is forced to all ones (2^WIDTH-1). Flags are unchanged.
- Undefined: diff is always the modulo-2^WIDTH result.
- Latency is identical in both builds.

Test Plan:
- Basic (WIDTH=74, CHUNK=16): minuend=100, subtrahend=58, out_ready=1 -> out_valid rises 5 edges after accept; diff=42, underflow=0, overflow=0; in_ready=1 one cycle after the output handshake.
- Cross-chunk borrow: minuend=2^16, subtrahend=1 -> diff=0xFFFF, flags 0. Then minuend=2^64, subtrahend=1 -> diff=2^64-1.
- Underflow: minuend=0, subtrahend=1 -> underflow=1, overflow=0; diff=2^74-1 without the macro, diff=0 with ADDER_SUM_SPLITTER_SATURATE_EN.
- Overflow: minuend=2^74, subtrahend=0 -> overflow=1, underflow=0; diff=0 without the macro, diff=2^74-1 with it.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises while pulsing in_valid with new operands -> diff and flags stable, in_ready=0, new operands ignored. Raise out_ready -> out_valid falls, in_ready=1 next cycle, next operation correct.
- Reset mid-RUN: assert reset for 1 cycle at index 2 -> out_valid never rises for that operation; in_ready=1 in the first cycle after reset deasserts. Then the adder round-trip a=2^73+5, b=12345 (minuend=a+b, subtrahend=a) -> diff=12345, flags 0.
